joystick_reader: RTL and testbench

JOYSTICK_READER -- requirements
Module: joystick_reader

---
 rtl/joystick_reader.sv | 167 ++++++++++++++++
 tb/tb_joystick_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/joystick_reader.sv
// Polls two serial game pads over a shared latch/clock pair and pushes the
// combined 16-bit button word into a FIFO whenever it changes.
module joystick_reader #(
  parameter int POLL_DIV = 100000,
  parameter int HALF_BIT = 300
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        joy1_data,
  input  logic        joy2_data,
  output logic        joy_latch,
  output logic        joy_clk,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [15:0] fifo_data,
  output logic        overflow,
  output logic        busy
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int TW = $clog2(2 * HALF_BIT);

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LATCH  = 3'd1;
  localparam logic [2:0] ST_CLK_LO = 3'd2;
  localparam logic [2:0] ST_CLK_HI = 3'd3;
  localparam logic [2:0] ST_PUSH   = 3'd4;

  logic          r_j1_meta, r_j1_sync;
  logic          r_j2_meta, r_j2_sync;
  logic [PW-1:0] r_poll_cnt;
  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_pad1, r_pad2;
  logic [15:0]   r_last_word;
  logic          r_last_valid;

  logic          w_tick;
  logic [15:0]   w_word;
  logic          w_changed;

  // Pad lines idle high, so the synchronizers reset to the "released" level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_j1_meta <= 1'b1;
      r_j1_sync <= 1'b1;
      r_j2_meta <= 1'b1;
      r_j2_sync <= 1'b1;
    end else begin
      r_j1_meta <= joy1_data;
      r_j1_sync <= r_j1_meta;
      r_j2_meta <= joy2_data;
      r_j2_sync <= r_j2_meta;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_poll_cnt <= '0;
    end else if (r_poll_cnt == POLL_LAST) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  assign w_tick    = (r_poll_cnt == POLL_LAST);
  assign w_word    = {r_pad2, r_pad1};
  assign w_changed = !r_last_valid || (w_word != r_last_word);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_bit_idx    <= '0;
      r_pad1       <= '0;
      r_pad2       <= '0;
      r_last_word  <= '0;
      r_last_valid <= 1'b0;
      joy_latch    <= 1'b0;
      joy_clk      <= 1'b1;
      fifo_wrreq   <= 1'b0;
      fifo_data    <= '0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fifo_wrreq <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick && enable) begin
            r_state   <= ST_LATCH;
            r_timer   <= '0;
            r_bit_idx <= '0;
            joy_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (r_timer == LATCH_LAST) begin
            r_state   <= ST_CLK_LO;
            r_timer   <= '0;
            joy_latch <= 1'b0;
            joy_clk   <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CLK_LO: begin
          // Sample as late as possible in the low phase so the pad output has settled.
          if (r_timer == HALF_LAST) begin
            r_pad1[r_bit_idx] <= ~r_j1_sync;
            r_pad2[r_bit_idx] <= ~r_j2_sync;
            r_state           <= ST_CLK_HI;
            r_timer           <= '0;
            joy_clk           <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CLK_HI: begin
          if (r_timer == HALF_LAST) begin
            r_timer <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_PUSH;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_state   <= ST_CLK_LO;
              joy_clk   <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_PUSH: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          // A dropped word leaves last_word stale so the next scan retries it.
          if (w_changed) begin
            if (!fifo_full) begin
              fifo_wrreq   <= 1'b1;
              fifo_data    <= w_word;
              r_last_word  <= w_word;
              r_last_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          joy_latch <= 1'b0;
          joy_clk   <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joystick_reader.sv
// Directed bench for joystick_reader: behavioural pad model, expected-word
// scoreboard and per-scan waveform measurements.
module tb_joystick_reader;

  localparam int POLL_DIV = 128;
  localparam int HALF_BIT = 4;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        enable;
  logic        joy1_data, joy2_data;
  logic        joy_latch, joy_clk;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [15:0] fifo_data;
  logic        overflow;
  logic        busy;

  logic [7:0]  btn1, btn2;
  logic [3:0]  pad_idx = 4'd8;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          checks   = 0;
  int          failures = 0;

  joystick_reader #(.POLL_DIV(POLL_DIV), .HALF_BIT(HALF_BIT)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .enable    (enable),
    .joy1_data (joy1_data),
    .joy2_data (joy2_data),
    .joy_latch (joy_latch),
    .joy_clk   (joy_clk),
    .fifo_full (fifo_full),
    .fifo_wrreq(fifo_wrreq),
    .fifo_data (fifo_data),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 sysclk = ~sysclk;

  // Pad model: latch loads bit 0 (A), each rising pad clock shifts to the next.
  always @(posedge joy_latch or posedge joy_clk) begin
    if (joy_latch) pad_idx <= 4'd0;
    else if (pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
  end

  assign joy1_data = (pad_idx < 4'd8) ? ~btn1[pad_idx[2:0]] : 1'b1;
  assign joy2_data = (pad_idx < 4'd8) ? ~btn2[pad_idx[2:0]] : 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge sysclk);
    if (fifo_wrreq === 1'b1) got_q.push_back(fifo_data);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_poll(output int lat, output int b_cyc, output int l_cyc,
                         output int pulses, output int lo_cyc);
    int n;
    logic prev_clk;
    lat = 0; b_cyc = 0; l_cyc = 0; pulses = 0; lo_cyc = 0; n = 0;
    while (busy !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
    if (busy !== 1'b1) check("poll_start_timeout", 32'(busy), 32'd1);
    prev_clk = 1'b1;
    while (busy === 1'b1 && n < 300) begin
      b_cyc++;
      if (joy_latch === 1'b1) l_cyc++;
      if (joy_clk === 1'b0) lo_cyc++;
      if (prev_clk === 1'b1 && joy_clk === 1'b0) pulses++;
      prev_clk = joy_clk;
      step();
      n++;
    end
    step();
    step();
  endtask

  int lat, b_cyc, l_cyc, pulses, lo_cyc;
  int rises;
  logic seen_latch, seen_clk_lo, seen_busy;
  logic prev_c;

  initial begin
    reset = 1'b0; enable = 1'b1; fifo_full = 1'b0;
    btn1 = 8'h81; btn2 = 8'h00;
    repeat (3) step();
    check("rst_latch", 32'(joy_latch), 32'd0);
    check("rst_clk", 32'(joy_clk), 32'd1);
    check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    check("rst_data", 32'(fifo_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // A + Right on pad 1; first tick POLL_DIV cycles after release.
    exp_q.push_back(16'h0081);
    reset = 1'b1;
    do_poll(lat, b_cyc, l_cyc, pulses, lo_cyc);
    check("first_tick_latency", 32'(lat), 32'(POLL_DIV));
    check("busy_cycles", 32'(b_cyc), 32'd73);
    check("latch_cycles", 32'(l_cyc), 32'd8);
    check("clk_pulses", 32'(pulses), 32'd8);
    check("clk_low_cycles", 32'(lo_cyc), 32'd32);
    check_writes("a_right");

    // Unchanged pads: no further writes.
    for (int i = 0; i < 2; i++) begin
      do_poll(lat, b_cyc, l_cyc, pulses, lo_cyc);
      check("hold_busy_cycles", 32'(b_cyc), 32'd73);
    end
    check_writes("hold");

    // Full FIFO drops the changed word, then the retry lands.
    fifo_full = 1'b1; btn1 = 8'h00; btn2 = 8'h08;
    do_poll(lat, b_cyc, l_cyc, pulses, lo_cyc);
    check_writes("full_drop");
    check("overflow_set", 32'(overflow), 32'd1);
    fifo_full = 1'b0;
    exp_q.push_back(16'h0800);
    do_poll(lat, b_cyc, l_cyc, pulses, lo_cyc);
    check_writes("retry");
    check("overflow_sticky", 32'(overflow), 32'd1);

    // All pressed, then all released.
    btn1 = 8'hFF; btn2 = 8'hFF;
    exp_q.push_back(16'hFFFF);
    do_poll(lat, b_cyc, l_cyc, pulses, lo_cyc);
    check_writes("all_pressed");
    repeat (10) step();
    check("data_hold", 32'(fifo_data), 32'hFFFF);
    btn1 = 8'h00; btn2 = 8'h00;
    exp_q.push_back(16'h0000);
    do_poll(lat, b_cyc, l_cyc, pulses, lo_cyc);
    check_writes("all_released");

    // Disabled across two ticks: pad lines stay static.
    enable = 1'b0; btn1 = 8'h10;
    seen_latch = 1'b0; seen_clk_lo = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (joy_latch !== 1'b0) seen_latch = 1'b1;
      if (joy_clk !== 1'b1) seen_clk_lo = 1'b1;
      if (busy !== 1'b0) seen_busy = 1'b1;
    end
    check("dis_latch_static", 32'(seen_latch), 32'd0);
    check("dis_clk_static", 32'(seen_clk_lo), 32'd0);
    check("dis_busy", 32'(seen_busy), 32'd0);
    check_writes("disabled");
    enable = 1'b1;
    exp_q.push_back(16'h0010);
    do_poll(lat, b_cyc, l_cyc, pulses, lo_cyc);
    check("reenable_latency", 32'(lat <= POLL_DIV), 32'd1);
    check_writes("reenable");

    // Reset during CLK_HI of bit 3 aborts the scan.
    btn1 = 8'h42; btn2 = 8'h24;
    lat = 0;
    while (busy !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
    rises = 0; prev_c = joy_clk; lat = 0;
    while (rises < 4 && lat < 300) begin
      step();
      lat++;
      if (prev_c === 1'b0 && joy_clk === 1'b1) rises++;
      prev_c = joy_clk;
    end
    check("bit3_reached", 32'(rises), 32'd4);
    step();
    #2 reset = 1'b0;
    #1;
    check("abort_latch", 32'(joy_latch), 32'd0);
    check("abort_clk", 32'(joy_clk), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wrreq", 32'(fifo_wrreq), 32'd0);
    check("abort_data", 32'(fifo_data), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    step();
    step();
    reset = 1'b1;
    exp_q.push_back(16'h2442);
    do_poll(lat, b_cyc, l_cyc, pulses, lo_cyc);
    check("post_reset_latency", 32'(lat), 32'(POLL_DIV));
    check("post_reset_busy", 32'(b_cyc), 32'd73);
    check_writes("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
